fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches the ROM word into a
// registered decode slot, absorbs unconditional JMPs and takes execute redirects.
module fetch_unit #(
  parameter int          ADDR_W     = 4,
  parameter int          INSTR_W    = 16,
  parameter logic [3:0]  JMP_OPCODE = 4'b1000,
  parameter int          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [CNT_W-1:0]   issue_count
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic slot_free_s;
  logic xfer_s;
  logic is_jmp_s;

  assign xfer_s      = valid_q && instr_ready;
  assign slot_free_s = !valid_q || instr_ready;
  assign is_jmp_s    = (rom_data[INSTR_W-1:INSTR_W-4] == JMP_OPCODE);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    // A transfer counts even when a redirect flushes the slot on the same edge.
    if (xfer_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
    end else if (slot_free_s) begin
      if (is_jmp_s) begin
        pc_d    = rom_data[ADDR_W-1:0];
        valid_d = 1'b0;
      end else begin
        instr_d = rom_data;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural 16x16 ROM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_addr = 4'd0;
  logic [15:0] instr_out;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] issue_count;

  logic [15:0] rom [0:15];
  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] prog [0:6];

  assign rom_data = rom[rom_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic load_prog();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 7; i++) rom[i] = prog[i];
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 4'd0; instr_ready = rdy;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_prog();
    do_reset(1'b0);
    n_checks++;
    if ({instr_valid, rom_addr, instr_pc, instr_out, issue_count} !== {1'b0, 4'd0, 4'd0, 16'h0000, 16'd0}) begin
      n_fail++;
      $display("FAIL reset: valid=%0b addr=%0d ipc=%0d instr=%h cnt=%0d, required 0 0 0 0000 0",
               instr_valid, rom_addr, instr_pc, instr_out, issue_count);
    end
  endtask

  task automatic test_stream();
    load_prog();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({instr_valid, instr_pc, instr_out} !== {1'b1, 4'(i), prog[i]}) begin
        n_fail++;
        $display("FAIL stream[%0d]: valid=%0b pc=%0d instr=%h, required 1 %0d %h",
                 i, instr_valid, instr_pc, instr_out, i, prog[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({instr_valid, rom_addr, issue_count} !== {1'b0, 4'd0, 16'd6}) begin
      n_fail++;
      $display("FAIL stream_jmp_bubble: valid=%0b addr=%0d cnt=%0d, required 0 0 6",
               instr_valid, rom_addr, issue_count);
    end
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr_pc, instr_out, issue_count} !== {1'b1, 4'd0, 16'h1E09, 16'd6}) begin
      n_fail++;
      $display("FAIL stream_after_jmp: valid=%0b pc=%0d instr=%h cnt=%0d, required 1 0 1e09 6",
               instr_valid, instr_pc, instr_out, issue_count);
    end
  endtask

  task automatic test_stall();
    load_prog();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({instr_valid, instr_pc, instr_out, rom_addr, issue_count} !== {1'b1, 4'd0, 16'h1E09, 4'd1, 16'd0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%0b pc=%0d instr=%h addr=%0d cnt=%0d, required 1 0 1e09 1 0",
                 i, instr_valid, instr_pc, instr_out, rom_addr, issue_count);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr_pc, instr_out, issue_count} !== {1'b1, 4'd1, 16'hFE00, 16'd1}) begin
      n_fail++;
      $display("FAIL stall_release: valid=%0b pc=%0d instr=%h cnt=%0d, required 1 1 fe00 1",
               instr_valid, instr_pc, instr_out, issue_count);
    end
    @(negedge clk);
    n_checks++;
    if ({instr_pc, instr_out, issue_count} !== {4'd2, 16'h100A, 16'd2}) begin
      n_fail++;
      $display("FAIL stall_next: pc=%0d instr=%h cnt=%0d, required 2 100a 2",
               instr_pc, instr_out, issue_count);
    end
  endtask

  task automatic test_redirect();
    load_prog();
    do_reset(1'b1);
    @(negedge clk);
    @(negedge clk);
    // pc=2 here, slot holds 1:FE00
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 4'd4;
    @(negedge clk);
    n_checks++;
    if ({instr_valid, rom_addr, issue_count} !== {1'b0, 4'd4, 16'd1}) begin
      n_fail++;
      $display("FAIL redirect_flush: valid=%0b addr=%0d cnt=%0d, required 0 4 1",
               instr_valid, rom_addr, issue_count);
    end
    redirect_valid = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr_pc, instr_out} !== {1'b1, 4'd4, 16'hE1C0}) begin
      n_fail++;
      $display("FAIL redirect_target: valid=%0b pc=%0d instr=%h, required 1 4 e1c0",
               instr_valid, instr_pc, instr_out);
    end
    redirect_valid = 1'b1; redirect_addr = 4'd0;
    @(negedge clk);
    n_checks++;
    if ({instr_valid, rom_addr, issue_count} !== {1'b0, 4'd0, 16'd2}) begin
      n_fail++;
      $display("FAIL redirect_with_ready: valid=%0b addr=%0d cnt=%0d, required 0 0 2",
               instr_valid, rom_addr, issue_count);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) rom[i] = 16'h2000 + 16'(i);
    do_reset(1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      n_checks++;
      if ({instr_valid, instr_pc, instr_out} !== {1'b1, 4'((k-1) % 16), 16'h2000 + 16'((k-1) % 16)}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: valid=%0b pc=%0d instr=%h, required 1 %0d %h",
                 k, instr_valid, instr_pc, instr_out, (k-1) % 16, 16'h2000 + 16'((k-1) % 16));
      end
    end
    n_checks++;
    if (issue_count !== 16'd17) begin
      n_fail++;
      $display("FAIL wrap_count: cnt=%0d, required 17", issue_count);
    end
  endtask

  task automatic test_midrst();
    load_prog();
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_checks++;
    if ({instr_valid, rom_addr, instr_pc} !== {1'b1, 4'd5, 4'd4}) begin
      n_fail++;
      $display("FAIL midrst_setup: valid=%0b addr=%0d ipc=%0d, required 1 5 4",
               instr_valid, rom_addr, instr_pc);
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 4'd9;
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0;
    n_checks++;
    if ({instr_valid, rom_addr, issue_count} !== {1'b0, 4'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL midrst_state: valid=%0b addr=%0d cnt=%0d, required 0 0 0",
               instr_valid, rom_addr, issue_count);
    end
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr_pc, instr_out} !== {1'b1, 4'd0, 16'h1E09}) begin
      n_fail++;
      $display("FAIL midrst_first: valid=%0b pc=%0d instr=%h, required 1 0 1e09",
               instr_valid, instr_pc, instr_out);
    end
  endtask

  task automatic test_halt();
    load_prog();
    rom[0] = 16'h8000;
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({instr_valid, rom_addr, issue_count, instr_out} !== {1'b0, 4'd0, 16'd0, 16'h0000}) begin
        n_fail++;
        $display("FAIL halt[%0d]: valid=%0b addr=%0d cnt=%0d instr=%h, required 0 0 0 0000",
                 i, instr_valid, rom_addr, issue_count, instr_out);
      end
    end
  endtask

  initial begin
    prog[0] = 16'h1E09; prog[1] = 16'hFE00; prog[2] = 16'h100A; prog[3] = 16'hF000;
    prog[4] = 16'hE1C0; prog[5] = 16'hF000; prog[6] = 16'h8000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_midrst();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
